// File: rtl/ascon_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ascon_phase_ctrl_if
// Brief    : Handshake/control bundle between the Ascon phase controller and
//            its datapath (start, block counts, round/XOR strobes, status).
// Revision : 1.0
// ============================================================================
interface ascon_phase_ctrl_if #(
  parameter int NB_W = 4
);
  logic            start_i;
  logic [NB_W-1:0] nb_ad_i;
  logic [NB_W-1:0] nb_pt_i;
  logic            data_valid_i;
  logic            data_ready_o;
  logic            init_sel_o;
  logic            perm_en_o;
  logic [3:0]      round_o;
  logic            xor_data_o;
  logic            xor_key_begin_o;
  logic            xor_key_end_o;
  logic            xor_dom_sep_o;
  logic            cipher_valid_o;
  logic            tag_valid_o;
  logic            busy_o;
  logic            end_o;

  modport master (
    output start_i, nb_ad_i, nb_pt_i, data_valid_i,
    input  data_ready_o, init_sel_o, perm_en_o, round_o, xor_data_o,
           xor_key_begin_o, xor_key_end_o, xor_dom_sep_o,
           cipher_valid_o, tag_valid_o, busy_o, end_o
  );

  modport slave (
    input  start_i, nb_ad_i, nb_pt_i, data_valid_i,
    output data_ready_o, init_sel_o, perm_en_o, round_o, xor_data_o,
           xor_key_begin_o, xor_key_end_o, xor_dom_sep_o,
           cipher_valid_o, tag_valid_o, busy_o, end_o
  );
endinterface
`default_nettype wire

// File: rtl/ascon_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ascon_phase_ctrl
// Brief    : Ascon AEAD phase sequencer: init, AD absorb, PT encrypt, final
//            permutation and tag, driving round and XOR strobes to a datapath.
// Revision : 1.0
// ============================================================================
module ascon_phase_ctrl #(
  parameter int PA_ROUNDS = 12,
  parameter int PB_ROUNDS = 6,
  parameter int NB_W      = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  ascon_phase_ctrl_if.slave bus
);

  generate
    if (PB_ROUNDS < 1 || PB_ROUNDS > PA_ROUNDS || PA_ROUNDS > 16 || NB_W < 1)
    begin : g_bad_params
      $error("ascon_phase_ctrl: requires 1 <= PB_ROUNDS <= PA_ROUNDS <= 16");
    end
  endgenerate

  localparam logic [3:0] c_st_idle       = 4'd0;
  localparam logic [3:0] c_st_init_load  = 4'd1;
  localparam logic [3:0] c_st_init_perm  = 4'd2;
  localparam logic [3:0] c_st_ad_wait    = 4'd3;
  localparam logic [3:0] c_st_ad_perm    = 4'd4;
  localparam logic [3:0] c_st_pt_wait    = 4'd5;
  localparam logic [3:0] c_st_pt_perm    = 4'd6;
  localparam logic [3:0] c_st_final_perm = 4'd7;
  localparam logic [3:0] c_st_done       = 4'd8;

  // Both permutation lengths end on round PA_ROUNDS-1; the short one starts later.
  localparam logic [3:0]      c_last_round = 4'(PA_ROUNDS - 1);
  localparam logic [3:0]      c_pb_first   = 4'(PA_ROUNDS - PB_ROUNDS);
  localparam logic [NB_W-1:0] c_one_blk    = NB_W'(1);

  logic [3:0]      r_state;
  logic [3:0]      r_round;
  logic [NB_W-1:0] r_ad_cnt;
  logic [NB_W-1:0] r_pt_cnt;

  logic [3:0]      w_state_nxt;
  logic [3:0]      w_round_nxt;
  logic [NB_W-1:0] w_ad_cnt_nxt;
  logic [NB_W-1:0] w_pt_cnt_nxt;

  logic w_perm;
  logic w_last_round;
  logic w_wait;
  logic w_handshake;

  assign w_perm       = (r_state == c_st_init_perm) || (r_state == c_st_ad_perm) ||
                        (r_state == c_st_pt_perm)   || (r_state == c_st_final_perm);
  assign w_last_round = w_perm && (r_round == c_last_round);
  assign w_wait       = (r_state == c_st_ad_wait) || (r_state == c_st_pt_wait);
  assign w_handshake  = w_wait && bus.data_valid_i;

  always_comb begin
    w_state_nxt  = r_state;
    w_round_nxt  = r_round;
    w_ad_cnt_nxt = r_ad_cnt;
    w_pt_cnt_nxt = r_pt_cnt;
    case (r_state)
      c_st_idle: begin
        if (bus.start_i) begin
          w_ad_cnt_nxt = bus.nb_ad_i;
          w_pt_cnt_nxt = (bus.nb_pt_i == '0) ? c_one_blk : bus.nb_pt_i;
          w_state_nxt  = c_st_init_load;
        end
      end
      c_st_init_load: begin
        w_round_nxt = 4'd0;
        w_state_nxt = c_st_init_perm;
      end
      c_st_init_perm: begin
        if (w_last_round) begin
          w_round_nxt = 4'd0;
          w_state_nxt = (r_ad_cnt != '0) ? c_st_ad_wait : c_st_pt_wait;
        end else begin
          w_round_nxt = r_round + 4'd1;
        end
      end
      c_st_ad_wait: begin
        if (w_handshake) begin
          w_round_nxt = c_pb_first;
          w_state_nxt = c_st_ad_perm;
        end
      end
      c_st_ad_perm: begin
        if (w_last_round) begin
          w_round_nxt  = 4'd0;
          w_ad_cnt_nxt = r_ad_cnt - c_one_blk;
          w_state_nxt  = (r_ad_cnt == c_one_blk) ? c_st_pt_wait : c_st_ad_wait;
        end else begin
          w_round_nxt = r_round + 4'd1;
        end
      end
      c_st_pt_wait: begin
        if (w_handshake) begin
          if (r_pt_cnt == c_one_blk) begin
            w_round_nxt = 4'd0;
            w_state_nxt = c_st_final_perm;
          end else begin
            w_pt_cnt_nxt = r_pt_cnt - c_one_blk;
            w_round_nxt  = c_pb_first;
            w_state_nxt  = c_st_pt_perm;
          end
        end
      end
      c_st_pt_perm: begin
        if (w_last_round) begin
          w_round_nxt = 4'd0;
          w_state_nxt = c_st_pt_wait;
        end else begin
          w_round_nxt = r_round + 4'd1;
        end
      end
      c_st_final_perm: begin
        if (w_last_round) begin
          w_round_nxt = 4'd0;
          w_state_nxt = c_st_done;
        end else begin
          w_round_nxt = r_round + 4'd1;
        end
      end
      c_st_done: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_round_nxt = 4'd0;
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= c_st_idle;
      r_round  <= 4'd0;
      r_ad_cnt <= '0;
      r_pt_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_round  <= w_round_nxt;
      r_ad_cnt <= w_ad_cnt_nxt;
      r_pt_cnt <= w_pt_cnt_nxt;
    end
  end

  // Outputs decode the registered state, so an async reset clears them at once.
  assign bus.data_ready_o    = w_wait;
  assign bus.xor_data_o      = w_handshake;
  assign bus.cipher_valid_o  = (r_state == c_st_pt_wait) && bus.data_valid_i;
  assign bus.init_sel_o      = (r_state == c_st_init_load);
  assign bus.perm_en_o       = w_perm;
  assign bus.round_o         = w_perm ? r_round : 4'd0;
  assign bus.xor_key_begin_o = (r_state == c_st_final_perm) && (r_round == 4'd0);
  assign bus.xor_key_end_o   = w_last_round &&
                               ((r_state == c_st_init_perm) || (r_state == c_st_final_perm));
  assign bus.xor_dom_sep_o   = w_last_round &&
                               (((r_state == c_st_init_perm) && (r_ad_cnt == '0)) ||
                                ((r_state == c_st_ad_perm)   && (r_ad_cnt == c_one_blk)));
  assign bus.tag_valid_o     = (r_state == c_st_done);
  assign bus.end_o           = (r_state == c_st_done);
  assign bus.busy_o          = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_ascon_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_phase_ctrl
// Brief    : Bench for ascon_phase_ctrl (default and 8/4-round instances)
//            against a phase-by-phase expected output trace.
// Revision : 1.0
// ============================================================================
module tb_ascon_phase_ctrl;

  typedef struct packed {
    logic       valid;
    logic       ready;
    logic       init_sel;
    logic       perm;
    logic [3:0] round;
    logic       xd;
    logic       kb;
    logic       ke;
    logic       ds;
    logic       cv;
    logic       tv;
    logic       busy;
    logic       fin;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       start = 1'b0;
  logic [3:0] nb_ad = 4'd0;
  logic [3:0] nb_pt = 4'd0;
  logic       valid = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int tot_stalls;
  int done_idx;
  cyc_t exp_q[$];
  cyc_t obs;

  always #5 clk = ~clk;

  ascon_phase_ctrl_if #(.NB_W(4)) bus_a ();
  ascon_phase_ctrl_if #(.NB_W(4)) bus_b ();

  assign bus_a.start_i      = start & ~sel;
  assign bus_b.start_i      = start & sel;
  assign bus_a.nb_ad_i      = nb_ad;
  assign bus_b.nb_ad_i      = nb_ad;
  assign bus_a.nb_pt_i      = nb_pt;
  assign bus_b.nb_pt_i      = nb_pt;
  assign bus_a.data_valid_i = valid & ~sel;
  assign bus_b.data_valid_i = valid & sel;

  ascon_phase_ctrl dut_a (.clock_i(clk), .reset_i(rst), .bus(bus_a));
  ascon_phase_ctrl #(.PA_ROUNDS(8), .PB_ROUNDS(4), .NB_W(4))
    dut_b (.clock_i(clk), .reset_i(rst), .bus(bus_b));

  always_comb begin
    obs = '0;
    if (sel) begin
      obs.ready = bus_b.data_ready_o;   obs.init_sel = bus_b.init_sel_o;
      obs.perm  = bus_b.perm_en_o;      obs.round    = bus_b.round_o;
      obs.xd    = bus_b.xor_data_o;     obs.kb       = bus_b.xor_key_begin_o;
      obs.ke    = bus_b.xor_key_end_o;  obs.ds       = bus_b.xor_dom_sep_o;
      obs.cv    = bus_b.cipher_valid_o; obs.tv       = bus_b.tag_valid_o;
      obs.busy  = bus_b.busy_o;         obs.fin      = bus_b.end_o;
    end else begin
      obs.ready = bus_a.data_ready_o;   obs.init_sel = bus_a.init_sel_o;
      obs.perm  = bus_a.perm_en_o;      obs.round    = bus_a.round_o;
      obs.xd    = bus_a.xor_data_o;     obs.kb       = bus_a.xor_key_begin_o;
      obs.ke    = bus_a.xor_key_end_o;  obs.ds       = bus_a.xor_dom_sep_o;
      obs.cv    = bus_a.cipher_valid_o; obs.tv       = bus_a.tag_valid_o;
      obs.busy  = bus_a.busy_o;         obs.fin      = bus_a.end_o;
    end
  end

  // Expected per-cycle outputs, built phase by phase from cycle S onwards.
  task automatic push_perm(input int pa, input int first, input int n,
                           input bit key_b, input bit key_e, input bit dsep);
    cyc_t c;
    for (int r = 0; r < n; r++) begin
      c = '0; c.busy = 1; c.perm = 1; c.round = 4'(first + r);
      c.valid = 1'($urandom);
      c.kb = key_b && (r == 0);
      c.ke = key_e && (r == n - 1);
      c.ds = dsep && (r == n - 1);
      exp_q.push_back(c);
    end
  endtask

  task automatic push_block(input int stalls, input bit is_pt);
    cyc_t c;
    for (int k = 0; k < stalls; k++) begin
      c = '0; c.busy = 1; c.ready = 1; c.valid = 0;
      exp_q.push_back(c);
    end
    c = '0; c.busy = 1; c.ready = 1; c.valid = 1; c.xd = 1; c.cv = is_pt;
    exp_q.push_back(c);
    tot_stalls += stalls;
  endtask

  task automatic build_trace(input int pa, input int pb, input int nad, input int npt,
                             input int stall_max, input int pt_fixed, input int trailing);
    cyc_t c;
    int   n;
    exp_q.delete();
    tot_stalls = 0;
    n = (npt == 0) ? 1 : npt;
    c = '0; c.valid = 1'($urandom); exp_q.push_back(c);
    c = '0; c.busy = 1; c.init_sel = 1; c.valid = 1'($urandom); exp_q.push_back(c);
    push_perm(pa, 0, pa, 0, 1, nad == 0);
    for (int b = 0; b < nad; b++) begin
      push_block($urandom_range(0, stall_max), 0);
      push_perm(pa, pa - pb, pb, 0, 0, b == nad - 1);
    end
    for (int b = 0; b < n; b++) begin
      push_block((pt_fixed >= 0) ? pt_fixed : $urandom_range(0, stall_max), 1);
      if (b != n - 1) push_perm(pa, pa - pb, pb, 0, 0, 0);
    end
    push_perm(pa, 0, pa, 1, 1, 0);
    c = '0; c.busy = 1; c.tv = 1; c.fin = 1; exp_q.push_back(c);
    done_idx = exp_q.size() - 1;
    for (int k = 0; k < trailing; k++) begin
      c = '0; c.valid = 1'($urandom); exp_q.push_back(c);
    end
  endtask

  task automatic run_txn(input bit s, input int pa, input int pb, input int nad,
                         input int npt, input int stall_max, input int pt_fixed,
                         input bit busy_start, input int abort_at, input int exp_end,
                         input int trailing);
    cyc_t e, o;
    int   n, obs_end, cv_cnt, want_end;
    build_trace(pa, pb, nad, npt, stall_max, pt_fixed, trailing);
    n = (npt == 0) ? 1 : npt;
    want_end = (exp_end >= 0) ? exp_end
             : 2 + 2*pa + nad*(1 + pb) + n + (n - 1)*pb + tot_stalls;
    sel = s; obs_end = -1; cv_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      start = (i == 0) || (busy_start && i <= done_idx && $urandom_range(0, 1) == 1);
      nb_ad = (i == 0) ? 4'(nad) : 4'($urandom);
      nb_pt = (i == 0) ? 4'(npt) : 4'($urandom);
      valid = exp_q[i].valid;
      @(negedge clk);
      e = exp_q[i]; e.valid = 1'b0;
      o = obs;      o.valid = 1'b0;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL trace S+%0d (ad=%0d pt=%0d pa=%0d): got %h, expected %h",
                 i, nad, npt, pa, o, e);
      end
      if (obs.fin === 1'b1 && obs_end < 0) obs_end = i;
      if (obs.cv === 1'b1) cv_cnt++;
      if (i == abort_at) begin
        start = 0;
        #2 rst = 1;
        #1 vectors++;
        if (obs !== cyc_t'(0)) begin
          miscompares++;
          $display("FAIL async reset outputs: got %h, expected 0", obs);
        end
        @(posedge clk); @(negedge clk);
        vectors++;
        if (obs !== cyc_t'(0) || obs_end != -1) begin
          miscompares++;
          $display("FAIL reset hold: got outputs %h end at S+%0d, expected 0 and no end",
                   obs, obs_end);
        end
        rst = 0;
        return;
      end
    end
    start = 0;
    vectors++;
    if (obs_end != want_end) begin
      miscompares++;
      $display("FAIL end_o cycle: got S+%0d, expected S+%0d", obs_end, want_end);
    end
    vectors++;
    if (cv_cnt != n) begin
      miscompares++;
      $display("FAIL cipher_valid count: got %0d, expected %0d", cv_cnt, n);
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; valid = 0;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      @(negedge clk); #1;
      vectors++;
      if (obs !== cyc_t'(0)) begin
        miscompares++;
        $display("FAIL reset state dut%0d: got %h, expected 0", s, obs);
      end
    end
    rst = 0;
    sel = 0;
  endtask

  task automatic test_min_run();     run_txn(0, 12, 6, 0, 1, 0, -1, 0, -1, 27, 1); endtask
  task automatic test_ad_block();    run_txn(0, 12, 6, 1, 1, 0, -1, 0, -1, 34, 1); endtask
  task automatic test_multi_block(); run_txn(0, 12, 6, 2, 3, 0, -1, 0, -1, 55, 1); endtask
  task automatic test_pt_stall();    run_txn(0, 12, 6, 1, 1, 0,  5, 0, -1, 39, 1); endtask
  task automatic test_short_params(); run_txn(1, 8, 4, 1, 1, 0, -1, 1, -1, 24, 1); endtask

  task automatic test_reset_abort();
    run_txn(0, 12, 6, 1, 1, 0, -1, 0, 17, -1, 1);
    run_txn(0, 12, 6, 0, 1, 0, -1, 0, -1, 27, 1);
  endtask

  task automatic test_back_to_back();
    run_txn(0, 12, 6, 1, 2, 1, -1, 0, -1, -1, 0);
    run_txn(0, 12, 6, 0, 0, 1, -1, 0, -1, -1, 0);
    run_txn(1, 8, 4, 2, 1, 1, -1, 1, -1, -1, 1);
  endtask

  task automatic test_random();
    bit s;
    for (int k = 0; k < 10; k++) begin
      s = 1'($urandom_range(0, 1));
      run_txn(s, s ? 8 : 12, s ? 4 : 6, $urandom_range(0, 3), $urandom_range(0, 3),
              2, -1, 1'($urandom_range(0, 1)), -1, -1, $urandom_range(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_min_run();
    test_ad_block();
    test_multi_block();
    test_pt_stall();
    test_reset_abort();
    test_short_params();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
